// File: rtl/de_pipe_reg.sv
// -----------------------------------------------------------------------------
// de_pipe_reg
//
// D/E pipeline register of the five-stage MIPS core. Latches the D-stage
// decode results and register-file operands, then forwards M/W results onto
// the latched operands so the E-stage ALU sees current values.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   en, clr                    1 = load from D / 0 = hold; clr inserts a bubble
//   pc_d, instr_d              D-stage PC and instruction word
//   rs_addr_d, rt_addr_d       source register numbers
//   rs_data_d, rt_data_d       D-stage operand values
//   imm_d, alu_op_d, b_sel_d   immediate, ALU opcode, ALU b source select
//   reg_we_d, dst_d, t_new_d   destination write enable/number, Tnew
//   mem_we_d, wb_sel_d         store enable, writeback source
//   fwd_m_*, fwd_w_*           M/W stage forwarding sources
//   pc_e, instr_e              latched PC and instruction
//   alu_a, alu_b, alu_op_e     ALU operands (forwarded) and opcode
//   rt_fwd_e                   forwarded rt, store data for E/M
//   reg_we_e, dst_e, mem_we_e, wb_sel_e, t_new_e   latched controls
//   t_new_m_nxt                saturating t_new_e - 1 for the E/M register
//   valid_e                    E holds a real instruction
// -----------------------------------------------------------------------------
module de_pipe_reg #(
    parameter int          DW       = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] pc_d,
    input  logic [31:0]   instr_d,
    input  logic [4:0]    rs_addr_d,
    input  logic [4:0]    rt_addr_d,
    input  logic [DW-1:0] rs_data_d,
    input  logic [DW-1:0] rt_data_d,
    input  logic [DW-1:0] imm_d,
    input  logic [2:0]    alu_op_d,
    input  logic          b_sel_d,
    input  logic          reg_we_d,
    input  logic [4:0]    dst_d,
    input  logic [1:0]    t_new_d,
    input  logic          mem_we_d,
    input  logic [1:0]    wb_sel_d,
    input  logic          fwd_m_we,
    input  logic          fwd_w_we,
    input  logic [4:0]    fwd_m_dst,
    input  logic [4:0]    fwd_w_dst,
    input  logic [DW-1:0] fwd_m_data,
    input  logic [DW-1:0] fwd_w_data,
    input  logic          fwd_m_rdy,
    output logic [DW-1:0] pc_e,
    output logic [31:0]   instr_e,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op_e,
    output logic [DW-1:0] rt_fwd_e,
    output logic          reg_we_e,
    output logic [4:0]    dst_e,
    output logic          mem_we_e,
    output logic [1:0]    wb_sel_e,
    output logic [1:0]    t_new_e,
    output logic [1:0]    t_new_m_nxt,
    output logic          valid_e
);

    // Internal state not exposed directly on the ports.
    logic [4:0]    rs_addr_reg;
    logic [4:0]    rt_addr_reg;
    logic [DW-1:0] rs_data_reg;
    logic [DW-1:0] rt_data_reg;
    logic [DW-1:0] imm_reg;
    logic          b_sel_reg;

    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    // Forwarding onto the stored operands. $0 is never forwarded, and M only
    // counts once its result is actually produced (fwd_m_rdy); otherwise an
    // older W result to the same register may still be the right value.
    always_comb begin
        rs_fwd = rs_data_reg;
        if (rs_addr_reg != 5'd0) begin
            if (fwd_m_we && fwd_m_dst == rs_addr_reg && fwd_m_rdy)
                rs_fwd = fwd_m_data;
            else if (fwd_w_we && fwd_w_dst == rs_addr_reg)
                rs_fwd = fwd_w_data;
        end
    end

    always_comb begin
        rt_fwd = rt_data_reg;
        if (rt_addr_reg != 5'd0) begin
            if (fwd_m_we && fwd_m_dst == rt_addr_reg && fwd_m_rdy)
                rt_fwd = fwd_m_data;
            else if (fwd_w_we && fwd_w_dst == rt_addr_reg)
                rt_fwd = fwd_w_data;
        end
    end

    assign alu_a       = rs_fwd;
    assign alu_b       = b_sel_reg ? imm_reg : rt_fwd;
    assign rt_fwd_e    = rt_fwd;
    assign t_new_m_nxt = (t_new_e == 2'd0) ? 2'd0 : t_new_e - 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_e        <= DW'(RESET_PC);
            instr_e     <= '0;
            rs_addr_reg <= '0;
            rt_addr_reg <= '0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
            imm_reg     <= '0;
            b_sel_reg   <= 1'b0;
            alu_op_e    <= '0;
            reg_we_e    <= 1'b0;
            dst_e       <= '0;
            mem_we_e    <= 1'b0;
            wb_sel_e    <= '0;
            t_new_e     <= '0;
            valid_e     <= 1'b0;
        end else if (clr) begin
            // Bubble: same contents as reset, regardless of en.
            pc_e        <= DW'(RESET_PC);
            instr_e     <= '0;
            rs_addr_reg <= '0;
            rt_addr_reg <= '0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
            imm_reg     <= '0;
            b_sel_reg   <= 1'b0;
            alu_op_e    <= '0;
            reg_we_e    <= 1'b0;
            dst_e       <= '0;
            mem_we_e    <= 1'b0;
            wb_sel_e    <= '0;
            t_new_e     <= '0;
            valid_e     <= 1'b0;
        end else if (!en) begin
            // Hold: controls stay put, but the operands absorb whatever is
            // being forwarded now, so a W value that retires while stalled
            // is still seen after the producer has left the pipe.
            rs_data_reg <= rs_fwd;
            rt_data_reg <= rt_fwd;
        end else begin
            pc_e        <= pc_d;
            instr_e     <= instr_d;
            rs_addr_reg <= rs_addr_d;
            rt_addr_reg <= rt_addr_d;
            rs_data_reg <= rs_data_d;
            rt_data_reg <= rt_data_d;
            imm_reg     <= imm_d;
            b_sel_reg   <= b_sel_d;
            alu_op_e    <= alu_op_d;
            reg_we_e    <= reg_we_d;
            dst_e       <= dst_d;
            mem_we_e    <= mem_we_d;
            wb_sel_e    <= wb_sel_d;
            t_new_e     <= t_new_d;
            valid_e     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_de_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_de_pipe_reg
//
// Directed testbench for de_pipe_reg: reset, load, M/W forwarding priority,
// $0 suppression, hold with W capture, bubble over hold, immediate operand
// and Tnew countdown. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_de_pipe_reg;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          en, clr;
    logic [DW-1:0] pc_d;
    logic [31:0]   instr_d;
    logic [4:0]    rs_addr_d, rt_addr_d;
    logic [DW-1:0] rs_data_d, rt_data_d, imm_d;
    logic [2:0]    alu_op_d;
    logic          b_sel_d, reg_we_d, mem_we_d;
    logic [4:0]    dst_d;
    logic [1:0]    t_new_d, wb_sel_d;
    logic          fwd_m_we, fwd_w_we, fwd_m_rdy;
    logic [4:0]    fwd_m_dst, fwd_w_dst;
    logic [DW-1:0] fwd_m_data, fwd_w_data;
    logic [DW-1:0] pc_e, alu_a, alu_b, rt_fwd_e;
    logic [31:0]   instr_e;
    logic [2:0]    alu_op_e;
    logic          reg_we_e, mem_we_e, valid_e;
    logic [4:0]    dst_e;
    logic [1:0]    wb_sel_e, t_new_e, t_new_m_nxt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    de_pipe_reg #(.DW(DW), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .pc_d(pc_d), .instr_d(instr_d),
        .rs_addr_d(rs_addr_d), .rt_addr_d(rt_addr_d),
        .rs_data_d(rs_data_d), .rt_data_d(rt_data_d), .imm_d(imm_d),
        .alu_op_d(alu_op_d), .b_sel_d(b_sel_d), .reg_we_d(reg_we_d),
        .dst_d(dst_d), .t_new_d(t_new_d), .mem_we_d(mem_we_d), .wb_sel_d(wb_sel_d),
        .fwd_m_we(fwd_m_we), .fwd_w_we(fwd_w_we),
        .fwd_m_dst(fwd_m_dst), .fwd_w_dst(fwd_w_dst),
        .fwd_m_data(fwd_m_data), .fwd_w_data(fwd_w_data), .fwd_m_rdy(fwd_m_rdy),
        .pc_e(pc_e), .instr_e(instr_e), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op_e(alu_op_e), .rt_fwd_e(rt_fwd_e), .reg_we_e(reg_we_e),
        .dst_e(dst_e), .mem_we_e(mem_we_e), .wb_sel_e(wb_sel_e),
        .t_new_e(t_new_e), .t_new_m_nxt(t_new_m_nxt), .valid_e(valid_e)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        fwd_m_we = 0; fwd_w_we = 0; fwd_m_rdy = 0;
        fwd_m_dst = 0; fwd_w_dst = 0; fwd_m_data = 0; fwd_w_data = 0;
    endtask

    initial begin
        // ---- Reset ----
        reset = 0; en = 1; clr = 0;
        pc_d = 32'h3004; instr_d = 32'h0000_0001;
        rs_addr_d = 0; rt_addr_d = 0; rs_data_d = 0; rt_data_d = 0; imm_d = 0;
        alu_op_d = 3'd1; b_sel_d = 0; reg_we_d = 1; dst_d = 5'd3;
        t_new_d = 2'd1; mem_we_d = 0; wb_sel_d = 2'd2;
        clear_fwd();
        step(); step();
        check("rst_pc_e", pc_e, 32'h3000);
        check("rst_valid_e", 32'(valid_e), 0);
        check("rst_instr_e", instr_e, 0);
        check("rst_alu_op_e", 32'(alu_op_e), 0);
        check("rst_reg_we_e", 32'(reg_we_e), 0);
        check("rst_t_new_e", 32'(t_new_e), 0);
        $display("txn reset: pc_e=%h valid_e=%0d", pc_e, valid_e);

        // Release reset mid-cycle; next edge loads.
        reset = 1;
        step();
        check("load_pc_e", pc_e, 32'h3004);
        check("load_alu_op_e", 32'(alu_op_e), 1);
        check("load_t_new_e", 32'(t_new_e), 1);
        check("load_t_new_m_nxt", 32'(t_new_m_nxt), 0);
        check("load_valid_e", 32'(valid_e), 1);
        check("load_dst_e", 32'(dst_e), 3);
        check("load_wb_sel_e", 32'(wb_sel_e), 2);
        $display("txn load1: pc_e=%h alu_op_e=%0d t_new_m_nxt=%0d", pc_e, alu_op_e, t_new_m_nxt);

        // ---- M/W forwarding priority on rs ----
        rs_addr_d = 5'd5; rs_data_d = 32'h11; t_new_d = 2'd2;
        step();
        check("rs_nofwd", alu_a, 32'h11);
        check("tnew2_m_nxt", 32'(t_new_m_nxt), 1);
        fwd_m_we = 1; fwd_m_dst = 5'd5; fwd_m_rdy = 1; fwd_m_data = 32'hAA;
        fwd_w_we = 1; fwd_w_dst = 5'd5; fwd_w_data = 32'hBB;
        #1;
        check("rs_fwd_m_prio", alu_a, 32'hAA);
        fwd_m_rdy = 0;
        #1;
        check("rs_fwd_w_m_notrdy", alu_a, 32'hBB);
        fwd_w_we = 0;
        #1;
        check("rs_fwd_none", alu_a, 32'h11);
        $display("txn fwd: M>W priority and M ready gating checked");

        // ---- $0 never forwarded ----
        clear_fwd();
        rs_addr_d = 5'd0; rs_data_d = 32'h55; t_new_d = 2'd3;
        step();
        fwd_m_we = 1; fwd_m_dst = 5'd0; fwd_m_rdy = 1; fwd_m_data = 32'hFF;
        fwd_w_we = 1; fwd_w_dst = 5'd0; fwd_w_data = 32'hFF;
        #1;
        check("rs_zero_nofwd", alu_a, 32'h55);
        check("tnew3_m_nxt", 32'(t_new_m_nxt), 2);
        $display("txn zero: alu_a=%h", alu_a);

        // ---- Hold with W capture on rt ----
        clear_fwd();
        pc_d = 32'h3008; instr_d = 32'hAC00_0007; rt_addr_d = 5'd7;
        rt_data_d = 32'h99; b_sel_d = 0; reg_we_d = 1; mem_we_d = 1; alu_op_d = 3'd0;
        step();
        check("rt_loaded", alu_b, 32'h99);
        en = 0;
        pc_d = 32'hDEAD; rt_data_d = 32'h0;
        fwd_w_we = 1; fwd_w_dst = 5'd7; fwd_w_data = 32'h1234;
        #1;
        check("hold1_alu_b", alu_b, 32'h1234);
        step();
        clear_fwd();
        #1;
        check("hold2_alu_b", alu_b, 32'h1234);
        check("hold2_rt_fwd_e", rt_fwd_e, 32'h1234);
        check("hold2_pc_e", pc_e, 32'h3008);
        check("hold2_valid_e", 32'(valid_e), 1);
        step();
        check("after_hold_alu_b", alu_b, 32'h1234);
        check("after_hold_mem_we_e", 32'(mem_we_e), 1);
        $display("txn hold: alu_b=%h pc_e=%h", alu_b, pc_e);

        // ---- Bubble wins over hold ----
        clr = 1; en = 0;
        step();
        check("clr_valid_e", 32'(valid_e), 0);
        check("clr_reg_we_e", 32'(reg_we_e), 0);
        check("clr_mem_we_e", 32'(mem_we_e), 0);
        check("clr_instr_e", instr_e, 0);
        check("clr_pc_e", pc_e, 32'h3000);
        check("clr_alu_b", alu_b, 0);
        $display("txn clr: valid_e=%0d instr_e=%h", valid_e, instr_e);

        // ---- Immediate operand, lui-style op, Tnew 0 ----
        clr = 0; en = 1;
        pc_d = 32'h300C; b_sel_d = 1; imm_d = 32'h0000_00FF; alu_op_d = 3'd4;
        t_new_d = 2'd0; rt_addr_d = 5'd9; rt_data_d = 32'h77; mem_we_d = 0;
        step();
        check("imm_alu_b", alu_b, 32'hFF);
        check("imm_alu_op_e", 32'(alu_op_e), 4);
        check("imm_t_new_m_nxt", 32'(t_new_m_nxt), 0);
        check("imm_rt_fwd_e", rt_fwd_e, 32'h77);
        check("imm_valid_e", 32'(valid_e), 1);
        $display("txn imm: alu_b=%h alu_op_e=%0d", alu_b, alu_op_e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
